// File: rtl/motor_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : motor_cmd_sequencer_if
// Brief    : Switch inputs and PWM-stage command outputs of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface motor_cmd_sequencer_if;
    logic       sw_on;
    logic [1:0] sw_speed;
    logic       sw_dir;
    logic [1:0] speed_sel;
    logic       dir_out;
    logic       motor_en;
    logic       busy;
    logic [2:0] state;

    modport master (
        output sw_on, sw_speed, sw_dir,
        input  speed_sel, dir_out, motor_en, busy, state
    );

    modport slave (
        input  sw_on, sw_speed, sw_dir,
        output speed_sel, dir_out, motor_en, busy, state
    );
endinterface
`default_nettype wire

// File: rtl/motor_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : motor_cmd_sequencer
// Brief    : Debounced switch front-end with ramped speed and safe reversal.
// Revision : 1.0 - initial release
// ============================================================================
module motor_cmd_sequencer #(
    parameter int DEBOUNCE_CYCLES  = 1_000_000,
    parameter int RAMP_STEP_CYCLES = 5_000_000,
    parameter int BRAKE_CYCLES     = 20_000_000
) (
    input  wire logic              clk,
    input  wire logic              rst,
    motor_cmd_sequencer_if.slave   cmd_if
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_W = $clog2(RAMP_STEP_CYCLES + 1);
    localparam int BR_W = $clog2(BRAKE_CYCLES + 1);
    localparam logic [DB_W-1:0] c_DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] c_RAMP_LAST = RP_W'(RAMP_STEP_CYCLES - 1);
    localparam logic [BR_W-1:0] c_BRK_LAST  = BR_W'(BRAKE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RAMP     = 3'd1,
        ST_RUN      = 3'd2,
        ST_REV_DOWN = 3'd3,
        ST_DWELL    = 3'd4
    } state_t;

    logic            r_on_s1, r_on_s2, r_dir_s1, r_dir_s2;
    logic [1:0]      r_spd_s1, r_spd_s2;
    logic            r_on_db, r_dir_db;
    logic [1:0]      r_spd_db, r_spd_cand;
    logic [DB_W-1:0] r_on_cnt, r_dir_cnt, r_spd_cnt;

    state_t          r_state;
    logic [1:0]      r_speed;
    logic            r_dir_out;
    logic [RP_W-1:0] r_ramp_cnt;
    logic [BR_W-1:0] r_dwell_cnt;

    logic [1:0]      w_target, w_goal;
    logic            w_rev_req, w_stepping;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_on_s1  <= 1'b0; r_on_s2  <= 1'b0;
            r_dir_s1 <= 1'b0; r_dir_s2 <= 1'b0;
            r_spd_s1 <= 2'd0; r_spd_s2 <= 2'd0;
        end else begin
            r_on_s1  <= cmd_if.sw_on;    r_on_s2  <= r_on_s1;
            r_dir_s1 <= cmd_if.sw_dir;   r_dir_s2 <= r_dir_s1;
            r_spd_s1 <= cmd_if.sw_speed; r_spd_s2 <= r_spd_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_on_db  <= 1'b0; r_on_cnt  <= '0;
            r_dir_db <= 1'b0; r_dir_cnt <= '0;
        end else begin
            if (r_on_s2 == r_on_db) begin
                r_on_cnt <= '0;
            end else if (r_on_cnt == c_DB_LAST) begin
                r_on_db  <= r_on_s2;
                r_on_cnt <= '0;
            end else begin
                r_on_cnt <= r_on_cnt + DB_W'(1);
            end

            if (r_dir_s2 == r_dir_db) begin
                r_dir_cnt <= '0;
            end else if (r_dir_cnt == c_DB_LAST) begin
                r_dir_db  <= r_dir_s2;
                r_dir_cnt <= '0;
            end else begin
                r_dir_cnt <= r_dir_cnt + DB_W'(1);
            end
        end
    end

    // The speed word tracks a candidate so a hop between two non-current codes also restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_spd_db   <= 2'd0;
            r_spd_cand <= 2'd0;
            r_spd_cnt  <= '0;
        end else if (r_spd_s2 == r_spd_db) begin
            r_spd_cnt  <= '0;
        end else if (r_spd_s2 != r_spd_cand) begin
            r_spd_cand <= r_spd_s2;
            r_spd_cnt  <= DB_W'(1);
        end else if (r_spd_cnt == c_DB_LAST) begin
            r_spd_db   <= r_spd_s2;
            r_spd_cnt  <= '0;
        end else begin
            r_spd_cnt  <= r_spd_cnt + DB_W'(1);
        end
    end

    always_comb begin
        w_target   = r_on_db ? r_spd_db : 2'd0;
        w_rev_req  = (r_dir_db != r_dir_out);
        w_goal     = (r_state == ST_REV_DOWN) ? 2'd0 : w_target;
        w_stepping = ((r_state == ST_RAMP) || (r_state == ST_REV_DOWN)) && (r_speed != w_goal);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_speed     <= 2'd0;
            r_dir_out   <= 1'b0;
            r_ramp_cnt  <= '0;
            r_dwell_cnt <= '0;
        end else begin
            if (w_stepping) begin
                if (r_ramp_cnt == c_RAMP_LAST) begin
                    r_ramp_cnt <= '0;
                    r_speed    <= (r_speed < w_goal) ? r_speed + 2'd1 : r_speed - 2'd1;
                end else begin
                    r_ramp_cnt <= r_ramp_cnt + RP_W'(1);
                end
            end else begin
                r_ramp_cnt <= '0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_rev_req)
                        r_dir_out <= ~r_dir_out;
                    else if (w_target != 2'd0)
                        r_state <= ST_RAMP;
                end
                ST_RAMP: begin
                    if (w_rev_req)
                        r_state <= ST_REV_DOWN;
                    else if (r_speed == w_target)
                        r_state <= (w_target == 2'd0) ? ST_IDLE : ST_RUN;
                end
                ST_RUN: begin
                    if (w_rev_req)
                        r_state <= ST_REV_DOWN;
                    else if (r_speed != w_target)
                        r_state <= ST_RAMP;
                end
                ST_REV_DOWN: begin
                    if (!w_rev_req && (r_speed != 2'd0)) begin
                        r_state <= ST_RAMP;
                    end else if (r_speed == 2'd0) begin
                        r_state     <= ST_DWELL;
                        r_dwell_cnt <= '0;
                    end
                end
                ST_DWELL: begin
                    if (r_dwell_cnt == c_BRK_LAST) begin
                        r_dwell_cnt <= '0;
                        if (w_rev_req)
                            r_dir_out <= ~r_dir_out;
                        r_state <= (w_target != 2'd0) ? ST_RAMP : ST_IDLE;
                    end else begin
                        r_dwell_cnt <= r_dwell_cnt + BR_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_if.speed_sel = r_speed;
    assign cmd_if.dir_out   = r_dir_out;
    assign cmd_if.motor_en  = (r_speed != 2'd0);
    assign cmd_if.busy      = (r_state == ST_RAMP) || (r_state == ST_REV_DOWN) || (r_state == ST_DWELL);
    assign cmd_if.state     = r_state;
endmodule
`default_nettype wire
